// File: rtl/mem_access_ctrl.sv
// CPU-to-memory access sequencer for a 16-bit memory with a level trigger handshake.
// A stale trigger is drained before issue, and DRAIN/WAIT_TRIG are bounded by a timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int SETTLE_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [10:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  output logic [10:0] mem_address,
  output logic [15:0] mem_datain,
  output logic        mem_write_enable,
  input  logic [15:0] mem_dataout,
  input  logic        mem_trigger
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_TRIG = 3'd3,
    SETTLE    = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_abort;
  logic [TO_W-1:0] r_to;
  logic [TO_W-1:0] w_to_inc;
  logic            w_to_hit;
  logic            w_to_clr;
  logic [2:0]      r_settle;
  logic            r_lat_we;
  logic [10:0]     r_lat_addr;
  logic [15:0]     r_lat_wdata;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [15:0]     r_rdata;
  logic [10:0]     r_mem_addr;
  logic [15:0]     r_mem_wdata;
  logic            r_mem_we;

  // The incremented value is what gets compared, so the counter never needs to hold TIMEOUT_CYCLES itself.
  assign w_to_inc = r_to + TO_W'(1);
  assign w_to_hit = (w_to_inc == TO_W'(TIMEOUT_CYCLES));
  assign w_to_clr = ((w_next == DRAIN) && (r_state != DRAIN)) ||
                    ((w_next == WAIT_TRIG) && (r_state != WAIT_TRIG));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) w_next = DRAIN;
        else     w_next = IDLE;
      end
      DRAIN: begin
        if (!mem_trigger) begin
          w_next = ISSUE;
        end else if (w_to_hit) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end else begin
          w_next = DRAIN;
        end
      end
      ISSUE: w_next = WAIT_TRIG;
      WAIT_TRIG: begin
        if (mem_trigger) begin
          w_next = SETTLE;
        end else if (w_to_hit) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end else begin
          w_next = WAIT_TRIG;
        end
      end
      SETTLE: begin
        if (r_settle == 3'd0) w_next = DONE;
        else                  w_next = SETTLE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to        <= '0;
      r_settle    <= 3'd0;
      r_lat_we    <= 1'b0;
      r_lat_addr  <= 11'h000;
      r_lat_wdata <= 16'h0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 16'h0000;
      r_mem_addr  <= 11'h000;
      r_mem_wdata <= 16'h0000;
      r_mem_we    <= 1'b0;
    end else begin
      if ((r_state == IDLE) && req) begin
        r_lat_we    <= req_we;
        r_lat_addr  <= req_addr;
        r_lat_wdata <= req_wdata;
      end

      if (w_to_clr) begin
        r_to <= '0;
      end else if ((r_state == DRAIN) || (r_state == WAIT_TRIG)) begin
        r_to <= w_to_inc;
      end

      if ((r_state == WAIT_TRIG) && (w_next == SETTLE)) begin
        r_settle <= 3'(SETTLE_CYCLES - 1);
      end else if ((r_state == SETTLE) && (r_settle != 3'd0)) begin
        r_settle <= r_settle - 3'd1;
      end

      // Address and data move only here, so the memory sees stable inputs between accesses.
      if (r_state == ISSUE) begin
        r_mem_addr  <= r_lat_addr;
        r_mem_wdata <= r_lat_wdata;
        r_mem_we    <= r_lat_we;
      end else if ((w_next == DONE) || (w_next == IDLE)) begin
        r_mem_we    <= 1'b0;
      end

      if ((r_state == SETTLE) && (w_next == DONE) && !r_lat_we) begin
        r_rdata <= mem_dataout;
      end else if (w_abort && !r_lat_we) begin
        r_rdata <= 16'h0000;
      end

      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      r_err  <= w_abort;
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;
  assign rdata            = r_rdata;
  assign mem_address      = r_mem_addr;
  assign mem_datain       = r_mem_wdata;
  assign mem_write_enable = r_mem_we;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a SETTLE_CYCLES=1 instance and a SETTLE_CYCLES=3
// instance share stimulus; a behavioural memory raises trigger when it sees a new access.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = 11'd0;
  logic [15:0] req_wdata = 16'd0;

  logic        busy1, done1, err1, mwe1, mtrig1, auto1;
  logic [15:0] rdata1, mdin1, mdout1;
  logic [10:0] maddr1;
  logic        busy2, done2, err2, mwe2, mtrig2, auto2;
  logic [15:0] rdata2, mdin2, mdout2;
  logic [10:0] maddr2;

  logic        trig_mode = 1'b1;
  logic        trig_force = 1'b0;
  logic        poke_en = 1'b0;
  logic [10:0] poke_addr = 11'd0;
  logic [15:0] poke_data = 16'd0;
  logic [15:0] mem [0:2047];
  logic [27:0] last1 = '0;
  logic [27:0] last2 = '0;

  int cyc = 0;
  int t_req = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  mem_access_ctrl #(.TIMEOUT_CYCLES(15), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy1), .done(done1), .err(err1), .rdata(rdata1),
    .mem_address(maddr1), .mem_datain(mdin1), .mem_write_enable(mwe1),
    .mem_dataout(mdout1), .mem_trigger(mtrig1));

  mem_access_ctrl #(.TIMEOUT_CYCLES(15), .SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy2), .done(done2), .err(err2), .rdata(rdata2),
    .mem_address(maddr2), .mem_datain(mdin2), .mem_write_enable(mwe2),
    .mem_dataout(mdout2), .mem_trigger(mtrig2));

  // Memory answers with a trigger in the cycle after its inputs change.
  assign auto1  = ({maddr1, mdin1, mwe1} != last1);
  assign auto2  = ({maddr2, mdin2, mwe2} != last2);
  assign mtrig1 = trig_mode ? trig_force : auto1;
  assign mtrig2 = trig_mode ? trig_force : auto2;
  assign mdout1 = mem[maddr1];
  assign mdout2 = mem[maddr2];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    last1 <= {maddr1, mdin1, mwe1};
    last2 <= {maddr2, mdin2, mwe2};
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (!trig_mode && auto1 && mwe1) mem[maddr1] <= mdin1;
  end

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    @(negedge clk); poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk); poke_en = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [10:0] a, input logic [15:0] wd,
                       input logic [15:0] erd, input logic eerr, input int elat);
    exp_t x;
    @(negedge clk);
    req = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    t_req = cyc;
    x.rdata = erd; x.err = eerr; x.lat = elat;
    sb.push_back(x);
  endtask

  task automatic collect(output bit got, output int lat, output logic [15:0] rd,
                         output logic e, output int wec);
    got = 1'b0; lat = 0; rd = 16'd0; e = 1'b0; wec = 0;
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (mwe1) wec++;
      if (done1) begin
        got = 1'b1; lat = cyc - t_req; rd = rdata1; e = err1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy1 || busy2) && k < 50) begin
      @(negedge clk); k++;
    end
    n_tests++;
    if (busy1 || busy2) begin
      n_fail++; $display("FAIL wait_idle: busy1=%0b busy2=%0b expected 0 within 50 cycles", busy1, busy2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; req = 1'b1; req_we = 1'b1; req_addr = 11'd5; req_wdata = 16'hFFFF;
    trig_mode = 1'b1; trig_force = 1'b0;
    repeat (2) @(negedge clk);
    poke(11'd5, 16'h1234); poke(11'd9, 16'h5A5A); poke(11'd2, 16'h0F0F); poke(11'd1, 16'h0001);
    n_tests++;
    if ({busy1, done1, err1, rdata1, maddr1, mdin1, mwe1} !== 47'd0) begin
      n_fail++; $display("FAIL reset_dut1: got %h expected 0", {busy1, done1, err1, rdata1, maddr1, mdin1, mwe1});
    end
    n_tests++;
    if ({busy2, done2, err2, rdata2, maddr2, mdin2, mwe2} !== 47'd0) begin
      n_fail++; $display("FAIL reset_dut2: got %h expected 0", {busy2, done2, err2, rdata2, maddr2, mdin2, mwe2});
    end
    @(negedge clk); reset = 1'b0; req = 1'b0; req_we = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy1 !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_req_ignored: busy cycles=%0d expected 0", bad);
    end
    trig_mode = 1'b0;
  endtask

  task automatic test_read();
    bit got; int lat; int wec; logic [15:0] rd; logic e; exp_t x;
    issue(1'b0, 11'd5, 16'h0000, 16'h1234, 1'b0, 5);
    collect(got, lat, rd, e, wec);
    x = sb.pop_front();
    n_tests++;
    if (!got || lat != x.lat) begin
      n_fail++; $display("FAIL read_latency: got=%0b lat=%0d expected %0d", got, lat, x.lat);
    end
    n_tests++;
    if (rd !== x.rdata || e !== x.err) begin
      n_fail++; $display("FAIL read_data: rdata=%h err=%b expected %h %b", rd, e, x.rdata, x.err);
    end
    n_tests++;
    if (wec != 0) begin
      n_fail++; $display("FAIL read_we: we cycles=%0d expected 0", wec);
    end
    @(negedge clk);
    n_tests++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL read_done_pulse: done=%b busy=%b expected 0 0", done1, busy1);
    end
    wait_idle();
  endtask

  task automatic test_write();
    bit got; int lat; int wec; logic [15:0] rd; logic e; exp_t x;
    issue(1'b1, 11'd3, 16'hC180, 16'h1234, 1'b0, 5);
    collect(got, lat, rd, e, wec);
    x = sb.pop_front();
    n_tests++;
    if (!got || lat != x.lat || rd !== x.rdata || e !== x.err) begin
      n_fail++; $display("FAIL write_done: got=%0b lat=%0d rdata=%h err=%b expected lat %0d rdata %h err %b",
                         got, lat, rd, e, x.lat, x.rdata, x.err);
    end
    n_tests++;
    if (wec != 2) begin
      n_fail++; $display("FAIL write_we: we cycles=%0d expected 2", wec);
    end
    wait_idle();
    n_tests++;
    if (mem[3] !== 16'hC180) begin
      n_fail++; $display("FAIL write_mem: word3=%h expected c180", mem[3]);
    end
    issue(1'b0, 11'd3, 16'h1111, 16'hC180, 1'b0, 5);
    collect(got, lat, rd, e, wec);
    x = sb.pop_front();
    n_tests++;
    if (!got || lat != x.lat || rd !== x.rdata || e !== x.err) begin
      n_fail++; $display("FAIL readback: got=%0b lat=%0d rdata=%h err=%b expected lat %0d rdata %h",
                         got, lat, rd, e, x.lat, x.rdata);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    bit got; int lat; int wec; logic [15:0] rd; logic e; exp_t x;
    trig_mode = 1'b1; trig_force = 1'b0;
    issue(1'b0, 11'd7, 16'h2222, 16'h0000, 1'b1, 18);
    collect(got, lat, rd, e, wec);
    x = sb.pop_front();
    n_tests++;
    if (!got || lat != x.lat) begin
      n_fail++; $display("FAIL timeout_latency: got=%0b lat=%0d expected %0d", got, lat, x.lat);
    end
    n_tests++;
    if (e !== x.err || rd !== x.rdata) begin
      n_fail++; $display("FAIL timeout_result: err=%b rdata=%h expected %b %h", e, rd, x.err, x.rdata);
    end
    wait_idle();
  endtask

  task automatic test_stale_trigger();
    bit got; int lat; int wec; logic [15:0] rd; logic e; exp_t x; int addr_bad;
    trig_mode = 1'b1; trig_force = 1'b1;
    issue(1'b0, 11'd9, 16'h3333, 16'h5A5A, 1'b0, 9);
    @(negedge clk); req = 1'b0;
    addr_bad = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) trig_mode = 1'b0;
      if (k <= 6 && maddr1 !== 11'd7) addr_bad++;
      if (k == 7 && maddr1 !== 11'd9) addr_bad++;
      @(negedge clk);
    end
    n_tests++;
    if (addr_bad != 0) begin
      n_fail++; $display("FAIL stale_addr: bad address cycles=%0d expected 0", addr_bad);
    end
    collect(got, lat, rd, e, wec);
    x = sb.pop_front();
    n_tests++;
    if (!got || lat != x.lat || rd !== x.rdata || e !== x.err) begin
      n_fail++; $display("FAIL stale_done: got=%0b lat=%0d rdata=%h err=%b expected lat %0d rdata %h",
                         got, lat, rd, e, x.lat, x.rdata);
    end
    wait_idle();
  endtask

  task automatic test_settle3();
    exp_t x1; exp_t x2; exp_t y;
    int lat1; int lat2; logic [15:0] rd1; logic [15:0] rd2;
    lat1 = -1; lat2 = -1; rd1 = 16'd0; rd2 = 16'd0;
    issue(1'b0, 11'd5, 16'h4444, 16'h1234, 1'b0, 5);
    y.rdata = 16'hABCD; y.err = 1'b0; y.lat = 7;
    sb.push_back(y);
    @(negedge clk); req = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin poke_en = 1'b1; poke_addr = 11'd5; poke_data = 16'hABCD; end
      if (k == 6) poke_en = 1'b0;
      if (done1 && lat1 < 0) begin lat1 = k; rd1 = rdata1; end
      if (done2 && lat2 < 0) begin lat2 = k; rd2 = rdata2; end
      @(negedge clk);
    end
    x1 = sb.pop_front();
    x2 = sb.pop_front();
    n_tests++;
    if (lat1 != x1.lat || rd1 !== x1.rdata) begin
      n_fail++; $display("FAIL settle1_read: lat=%0d rdata=%h expected %0d %h", lat1, rd1, x1.lat, x1.rdata);
    end
    n_tests++;
    if (lat2 != x2.lat || rd2 !== x2.rdata) begin
      n_fail++; $display("FAIL settle3_read: lat=%0d rdata=%h expected %0d %h", lat2, rd2, x2.lat, x2.rdata);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    exp_t x; int ndone; int lat; logic [15:0] rd;
    ndone = 0; lat = -1; rd = 16'd0;
    issue(1'b0, 11'd2, 16'h5555, 16'h0F0F, 1'b0, 5);
    @(negedge clk); req = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 2) begin req = 1'b1; req_we = 1'b1; req_addr = 11'd1; req_wdata = 16'hDEAD; end
      if (k == 6) req = 1'b0;
      if (done1) begin
        ndone++;
        if (lat < 0) begin lat = k; rd = rdata1; end
      end
      @(negedge clk);
    end
    x = sb.pop_front();
    n_tests++;
    if (ndone != 1 || lat != x.lat || rd !== x.rdata) begin
      n_fail++; $display("FAIL busy_ignore: dones=%0d lat=%0d rdata=%h expected 1 %0d %h",
                         ndone, lat, rd, x.lat, x.rdata);
    end
    n_tests++;
    if (mem[1] !== 16'h0001 || maddr1 !== 11'd2) begin
      n_fail++; $display("FAIL busy_no_latch: word1=%h addr=%h expected 0001 002", mem[1], maddr1);
    end
    wait_idle();
  endtask

  task automatic test_reset_midway();
    int ndone; int nbusy;
    trig_mode = 1'b1; trig_force = 1'b0;
    @(negedge clk);
    req = 1'b1; req_we = 1'b0; req_addr = 11'd6; req_wdata = 16'h6666;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; req = 1'b1; req_addr = 11'd8;
    @(negedge clk);
    n_tests++;
    if ({busy1, done1, err1, rdata1, maddr1, mdin1, mwe1} !== 47'd0) begin
      n_fail++; $display("FAIL reset_midway: got %h expected 0", {busy1, done1, err1, rdata1, maddr1, mdin1, mwe1});
    end
    reset = 1'b0; req = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (done1 || done2) ndone++;
      if (busy1 || busy2) nbusy++;
    end
    n_tests++;
    if (ndone != 0 || nbusy != 0) begin
      n_fail++; $display("FAIL reset_no_done: dones=%0d busy cycles=%0d expected 0 0", ndone, nbusy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_stale_trigger();
    test_settle3();
    test_back_to_back();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum cycles spent in DRAIN or WAIT_TRIG before an access is aborted.
REQ-002 Parameter SETTLE_CYCLES, default 1, legal range 1..7: cycles waited after trigger is seen before the read data is captured.
REQ-003 clk  in  1  single clock; every register updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req  in  1  CPU access request; sampled only in IDLE.
REQ-006 req_we  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  11  word address.
REQ-008 req_wdata  in  16  write data.
REQ-009 busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  high together with done when the access timed out.
REQ-012 rdata  out  16  read result; holds its value until the next read completes.
REQ-013 mem_address  out  11  word address driven to the 16-bit memory.
REQ-014 mem_datain  out  16  write data driven to the memory.
REQ-015 mem_write_enable  out  1  memory write strobe.
REQ-016 mem_dataout  in  16  memory read data.
REQ-017 mem_trigger  in  1  memory access-complete flag; level-sensitive.

Function
REQ-018 The FSM SHALL have exactly six states: IDLE, DRAIN, ISSUE, WAIT_TRIG, SETTLE, DONE.
REQ-019 In IDLE with req=1, the block SHALL latch req_we, req_addr and req_wdata and move to DRAIN; busy SHALL be 1 from the next cycle.
REQ-020 A req while busy=1 SHALL be ignored, neither queued nor latched.
REQ-021 DRAIN: if mem_trigger=0, go to ISSUE.
  - This prevents a stale trigger from a previous access completing the new one.
REQ-022 ISSUE: register the latched address, data and we onto mem_address, mem_datain and mem_write_enable, then go to WAIT_TRIG.
REQ-023 WAIT_TRIG: if mem_trigger=1, load the settle counter and go to SETTLE.
REQ-024 SETTLE: after SETTLE_CYCLES cycles, go to DONE.
  - For a read, rdata SHALL be loaded from mem_dataout on the DONE-entry edge.
REQ-025 DONE: done=1 for one cycle, mem_write_enable=0, then return to IDLE.
REQ-026 A timeout counter SHALL clear on DRAIN entry and on WAIT_TRIG entry, and increment in each of those states.
  - When it reaches TIMEOUT_CYCLES, the FSM SHALL go to DONE with err=1.
  - rdata SHALL be 16'h0000 after a timed-out read.
  - The counter SHALL be wide enough for TIMEOUT_CYCLES without wrap-around.
REQ-027 mem_address and mem_datain SHALL change only in ISSUE and SHALL hold their values in IDLE, so the memory sees no spurious status change between accesses.
REQ-028 mem_write_enable SHALL be 1 only from ISSUE through SETTLE of a write access.
REQ-029 If mem_trigger is already 1 in WAIT_TRIG's first cycle, that level SHALL be accepted, because DRAIN has already observed 0.
REQ-030 Minimum latency (trigger low at acceptance, high on WAIT_TRIG entry, SETTLE_CYCLES=1): req sampled on cycle 0 -> done=1 on cycle 5.
REQ-031 done and err SHALL never be 1 outside DONE.
REQ-032 In IDLE, busy SHALL be 0.

Reset
REQ-033 On reset=1 at a clock edge, the block SHALL go to IDLE, abandoning any access in progress, and SHALL set:
  - busy=0, done=0, err=0
  - rdata=16'h0000
  - mem_address=11'h000, mem_datain=16'h0000, mem_write_enable=0
  - timeout and settle counters = 0
REQ-034 A req presented in the same cycle as reset=1 SHALL be ignored.

Verification
REQ-035 Read: memory model holds 16'h1234 at word 5 and raises trigger 1 cycle after the address changes; req=1, req_we=0, req_addr=5 -> done pulse on cycle 5, rdata=16'h1234, err=0, mem_write_enable stays 0.
REQ-036 Write: req_we=1, addr=3, wdata=16'hC180 -> mem_write_enable=1 from ISSUE until DONE; model word 3 = 16'hC180; a following read of word 3 returns 16'hC180.
REQ-037 Stale trigger: mem_trigger held 1 for 4 cycles after acceptance -> FSM stays in DRAIN for those 4 cycles; mem_address does not change until trigger has been seen at 0.
REQ-038 Timeout: mem_trigger stuck at 0, read of word 7 -> done=1 and err=1 exactly 15 cycles after WAIT_TRIG entry; rdata=16'h0000.
REQ-039 Busy and reset: second req while busy=1 -> ignored, one done only; reset asserted in WAIT_TRIG -> next cycle IDLE with all outputs at their reset values and no done pulse.
REQ-040 SETTLE_CYCLES=3 build: the REQ-035 read -> done on cycle 7; rdata captures mem_dataout as sampled on the DONE-entry edge.
